// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator: animation modes, FSM state
// encoding and the default power-on pattern.
package led_pkg;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_ROTL   = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  localparam logic [7:0] RESET_PAT_DEF = 8'hAA;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Pattern after one animation step. BLINK uses the phase being entered:
  // phase 1 blanks the LEDs, phase 0 shows the base pattern again.
  function automatic logic [7:0] step_pattern(input logic [1:0] mode,
                                              input logic [7:0] cur,
                                              input logic [7:0] base,
                                              input logic       next_phase);
    logic [7:0] nxt;
    nxt = cur;
    case (mode)
      MODE_ROTL:  nxt = {cur[6:0], cur[7]};
      MODE_BLINK: nxt = next_phase ? 8'h00 : base;
      MODE_COUNT: nxt = cur + 8'd1;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 and flags the terminal count as a
// tick. A clear restarts the count; hold freezes it without losing position.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);
  assign tick   = at_max & ~hold;

  // Next count: clear has priority over hold so a command reloads the phase
  // of the animation even while frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (at_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern source: accepts a pattern/mode command over valid/ready and
// animates it (static, rotate-left, blink, count) once per prescaled step.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int         TICK_DIV  = 25_000_000,
  parameter logic [7:0] RESET_PAT = RESET_PAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_data,
  input  logic       freeze,
  output logic [7:0] led_out,
  output logic       step_tick
);

  state_t     state_q,     state_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic [7:0] led_q,       led_d;
  logic [7:0] base_q,      base_d;
  logic [1:0] mode_q,      mode_d;
  logic       phase_q,     phase_d;
  logic       step_tick_q, step_tick_d;

  logic tick;
  logic accept;
  logic apply_step;

  // A command is taken whenever the registered ready is high; the prescaler
  // is cleared on that same edge so the next step lands TICK_DIV edges later.
  assign accept = cmd_valid & cmd_ready_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .hold (freeze),
    .tick (tick)
  );

  // An accept on the tick edge wins and the tick is dropped.
  assign apply_step = tick & (state_q == ST_RUN) & ~accept;

  // Next-state and next-output logic for the command FSM and pattern regs.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    led_d       = led_q;
    base_d      = base_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    step_tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          state_d     = ST_LOAD;
          cmd_ready_d = 1'b0;
          led_d       = cmd_data;
          base_d      = cmd_data;
          mode_d      = cmd_mode;
          phase_d     = 1'b0;
        end else if (apply_step) begin
          step_tick_d = 1'b1;
          if (mode_q == MODE_BLINK) begin
            phase_d = ~phase_q;
          end
          led_d = step_pattern(mode_q, led_q, base_q, ~phase_q);
        end
      end
      ST_LOAD: begin
        state_d     = ST_RUN;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_RUN;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // FSM, pattern and output registers; reset returns to the power-on pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cmd_ready_q <= 1'b1;
      led_q       <= RESET_PAT;
      base_q      <= RESET_PAT;
      mode_q      <= MODE_STATIC;
      phase_q     <= 1'b0;
      step_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      led_q       <= led_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign led_out   = led_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a 4-cycle step period.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_data;
  logic       freeze;
  logic [7:0] led_out;
  logic       step_tick;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(
    .TICK_DIV  (4),
    .RESET_PAT (8'hAA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_data  (cmd_data),
    .freeze    (freeze),
    .led_out   (led_out),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n_quiet edges with no step, then one edge that must step to exp.
  task automatic tick_after(input int n_quiet, input logic [7:0] exp, input string tag);
    logic [7:0] held;
    held = led_out;
    for (int i = 0; i < n_quiet; i++) begin
      step();
      chk({tag, "_quiet_tick"}, {7'b0, step_tick}, 8'h00);
      chk({tag, "_quiet_led"}, led_out, held);
    end
    step();
    chk({tag, "_tick"}, {7'b0, step_tick}, 8'h01);
    chk({tag, "_led"}, led_out, exp);
  endtask

  // Single-cycle command, checking the load edge and the LOAD cycle.
  task automatic do_cmd(input logic [1:0] m, input logic [7:0] d, input string tag);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
    chk({tag, "_load_led"}, led_out, d);
    chk({tag, "_load_ready"}, {7'b0, cmd_ready}, 8'h00);
    chk({tag, "_load_tick"}, {7'b0, step_tick}, 8'h00);
    step();
    chk({tag, "_ready_back"}, {7'b0, cmd_ready}, 8'h01);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_data  = 8'h00;
    freeze    = 1'b0;
    #3;
    chk("rst_led", led_out, 8'hAA);
    chk("rst_ready", {7'b0, cmd_ready}, 8'h01);
    chk("rst_tick", {7'b0, step_tick}, 8'h00);
    step();
    step();
    rst = 1'b0;

    // Idle STATIC: pulses every 4 edges, pattern unchanged.
    tick_after(3, 8'hAA, "static1");
    tick_after(3, 8'hAA, "static2");

    // ROTL from 81.
    do_cmd(2'b01, 8'h81, "rotl");
    tick_after(2, 8'h03, "rotl1");
    tick_after(3, 8'h06, "rotl2");
    tick_after(3, 8'h0C, "rotl3");
    tick_after(3, 8'h18, "rotl4");

    // COUNT wraps FF -> 00.
    do_cmd(2'b11, 8'hFE, "count");
    tick_after(2, 8'hFF, "count1");
    tick_after(3, 8'h00, "count2");
    tick_after(3, 8'h01, "count3");

    // BLINK, then freeze with prescaler at 2.
    do_cmd(2'b10, 8'h3C, "blink");
    tick_after(2, 8'h00, "blink1");
    tick_after(3, 8'h3C, "blink2");
    step();
    step();
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_led", led_out, 8'h3C);
      chk("frz_tick", {7'b0, step_tick}, 8'h00);
    end
    freeze = 1'b0;
    tick_after(1, 8'h00, "frz_resume");

    // Freeze right at terminal count: tick suppressed until release.
    step();
    step();
    step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz3_led", led_out, 8'h00);
      chk("frz3_tick", {7'b0, step_tick}, 8'h00);
    end
    freeze = 1'b0;
    tick_after(0, 8'h3C, "frz3_resume");

    // Command accepted while frozen; animation waits for release.
    freeze = 1'b1;
    do_cmd(2'b11, 8'h10, "frzcmd");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frzcmd_led", led_out, 8'h10);
      chk("frzcmd_tick", {7'b0, step_tick}, 8'h00);
    end
    freeze = 1'b0;
    tick_after(3, 8'h11, "frzcmd_run");

    // Accept on the same edge as a tick: load wins, no step.
    step();
    step();
    step();
    do_cmd(2'b01, 8'h01, "collide");
    tick_after(2, 8'h02, "collide_next");

    // cmd_valid held across LOAD: second accept only once ready returns.
    cmd_valid = 1'b1;
    cmd_mode  = 2'b11;
    cmd_data  = 8'h40;
    step();
    chk("hold_load1", led_out, 8'h40);
    chk("hold_ready1", {7'b0, cmd_ready}, 8'h00);
    cmd_data = 8'h55;
    step();
    chk("hold_noreaccept", led_out, 8'h40);
    chk("hold_ready2", {7'b0, cmd_ready}, 8'h01);
    step();
    chk("hold_load2", led_out, 8'h55);
    chk("hold_ready3", {7'b0, cmd_ready}, 8'h00);
    cmd_valid = 1'b0;
    step();
    step();

    // Async reset between edges while counting.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_led", led_out, 8'hAA);
    chk("arst_ready", {7'b0, cmd_ready}, 8'h01);
    chk("arst_tick", {7'b0, step_tick}, 8'h00);
    #1;
    rst = 1'b0;
    tick_after(3, 8'hAA, "arst_static1");
    tick_after(3, 8'hAA, "arst_static2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Pattern source sitting directly upstream of the board LED output register; its led_out feeds the top-level LEDs_8Bit.
- Accepts a pattern byte plus mode over a valid/ready command port (fed by the serial driver or board switches).
- Animates the pattern at a prescaled step rate: static, rotate, blink or count.
- One clock domain, no external memory.

Parameters:
- TICK_DIV, 25_000_000, clk cycles per animation step (100 MHz -> 4 Hz); legal range 2..2^27.
- RESET_PAT, 8'b10101010, led_out value at reset.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_mode  input  2  00 STATIC, 01 ROTL, 10 BLINK, 11 COUNT.
- cmd_data  input  8  base pattern / count seed.
- freeze  input  1  level; holds animation and prescaler.
- led_out  output  8  registered LED drive.
- step_tick  output  1  one-cycle pulse on every applied animation step.

Behaviour:
- Reset (async, immediate):
  - led_out=RESET_PAT, base=RESET_PAT, mode=STATIC, phase=0, prescaler=0.
  - step_tick=0, cmd_ready=1, state=RUN.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted when count==TICK_DIV-1 and freeze=0.
  - Holds its value while freeze=1.
- FSM states:
  - RUN: cmd_ready=1; apply ticks.
  - LOAD: one cycle, cmd_ready=0.
  - Transitions: RUN->LOAD on accept (cmd_valid && cmd_ready); LOAD->RUN unconditionally.
- Accept at edge N:
  - On the same edge: led_out=cmd_data, base=cmd_data, mode=cmd_mode, phase=0, prescaler=0.
  - cmd_ready is low for the cycle after N and high again after edge N+1.
  - cmd_valid held across LOAD is not accepted twice; a second accept needs cmd_ready=1 again.
- Step on tick in RUN, applied at the same edge, with step_tick=1 for exactly that following cycle:
  - STATIC: led_out unchanged; step_tick still pulses.
  - ROTL: led_out = {led_out[6:0], led_out[7]}.
  - BLINK: phase toggles; phase 0 shows base, phase 1 shows 8'h00.
  - COUNT: led_out = led_out + 1, 8-bit wrap FF->00, no carry out.
- Tick in the LOAD state: not possible, because the prescaler was just cleared.
- Boundaries:
  - Accept and tick on the same edge: accept wins, the tick is discarded, no step_tick.
  - freeze=1: led_out and phase hold and no step_tick. Commands are still accepted and loaded (led_out updates), and animation stays held until freeze=0.
  - freeze released: counting resumes from the held prescaler value, not from 0.
  - rst mid-LOAD or mid-count: immediate return to reset values; a pending command is lost.
- Latency:
  - Command to led_out: 1 edge.
  - First step after a load: exactly TICK_DIV edges after the load edge (with freeze=0).

Decomposition:
- led_pkg holds:
  - Mode constants MODE_STATIC/ROTL/BLINK/COUNT (2-bit).
  - State encoding ST_RUN/ST_LOAD.
  - Default RESET_PAT constant 8'hAA.
- Sub-module tick_prescaler:
  - Parameters: TICK_DIV, width from clog2.
  - Ports: clk, rst, clr, hold, tick.
- Top holds the FSM, mode and pattern registers, and the output register.

Test Plan (TICK_DIV=4):
- Reset and hold: rst pulse, then no command -> led_out=8'hAA, cmd_ready=1; step_tick every 4 cycles; led_out stays AA.
- ROTL: load mode 01, data 8'h81 -> next cycle led_out=81, cmd_ready=0 for 1 cycle. Ticks then give 03, 06, 0C, 18, one per 4 cycles, each with a single step_tick.
- COUNT wrap: load mode 11, data 8'hFE -> FE, FF, 00, 01 on successive ticks.
- BLINK and freeze: load mode 10, data 8'h3C -> 3C, 00, 3C. Raise freeze for 10 cycles -> led_out constant, no step_tick. Release -> next tick arrives after the remaining prescaler count.
- Accept/tick collision: assert cmd_valid (mode 01, data 8'h01) on the cycle the prescaler reaches 3 -> led_out=01 with no rotate and no step_tick; next step comes 4 cycles later (02). Holding cmd_valid across LOAD -> second accept only when cmd_ready=1.
- Async reset mid-COUNT: assert rst between edges while counting -> led_out=AA immediately, mode STATIC, prescaler restarts at 0.
